// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction buffer, including the
// decode-side immediate field slices taken from the head instruction.
interface if_id_buffer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [11:0]     iimm;
  logic [11:0]     simm;
  logic [11:0]     bimm;
  logic [19:0]     uimm;
  logic [19:0]     jimm;
  logic [4:0]      i_smm;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr,
    output iimm, simm, bimm, uimm, jimm, i_smm
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr,
    input  iimm, simm, bimm, uimm, jimm, i_smm
  );
endinterface

// File: rtl/if_id_buffer.sv
// Circular IF/ID buffer queuing {pc, instr} pairs, with flush and immediate slices.
// Optional saturating stall/flush-drop counters are enabled by IFID_PERF_CNT_EN.
module if_id_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  if_id_buffer_if.slave     bus
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_drop_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  // Handshake flags come from registered count only, never from out_ready.
  assign bus.in_ready  = (r_count != CW'(DEPTH));
  assign bus.out_valid = (r_count != CW'(0));
  assign w_push = bus.in_valid & bus.in_ready & ~bus.flush;
  assign w_pop  = bus.out_valid & bus.out_ready & ~bus.flush;

  // Storage write port; the array itself is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]    <= bus.in_pc;
      r_instr_mem[r_wptr] <= bus.in_instr;
    end
  end

  // Pointer and occupancy state; flush outranks push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry, or a NOP at pc 0 while empty.
  always_comb begin
    bus.out_pc    = '0;
    bus.out_instr = NOP_INSTR;
    if (bus.out_valid) begin
      bus.out_pc    = r_pc_mem[r_rptr];
      bus.out_instr = r_instr_mem[r_rptr];
    end else begin
      bus.out_pc    = '0;
      bus.out_instr = NOP_INSTR;
    end
  end

  assign bus.iimm  = bus.out_instr[31:20];
  assign bus.simm  = {bus.out_instr[31:25], bus.out_instr[11:7]};
  assign bus.bimm  = {bus.out_instr[31], bus.out_instr[7], bus.out_instr[30:25], bus.out_instr[11:8]};
  assign bus.uimm  = bus.out_instr[31:12];
  assign bus.jimm  = {bus.out_instr[31], bus.out_instr[19:12], bus.out_instr[20], bus.out_instr[30:21]};
  assign bus.i_smm = bus.out_instr[24:20];

`ifdef IFID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_drop_cnt;
  logic [32:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_flush_drop_cnt} + 33'(r_count);

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt      <= 32'd0;
      r_flush_drop_cnt <= 32'd0;
    end else begin
      if (bus.out_valid && !bus.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (bus.flush) begin
        r_flush_drop_cnt <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
      end
    end
  end

  assign stall_cnt      = r_stall_cnt;
  assign flush_drop_cnt = r_flush_drop_cnt;
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer (DEPTH=2, XLEN=32).
module tb_if_id_buffer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  if_id_buffer_if #(.XLEN(32)) bus ();

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_drop_cnt;
`endif

  if_id_buffer #(.DEPTH(2), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_drop_cnt (flush_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = 32'd0;
    bus.in_instr  = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_instr", bus.out_instr, 32'h0000_0013);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_iimm", 32'(bus.iimm), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Fill with backpressure; third entry must be held, not lost.
    push_one(32'h100, 32'h0050_0093);
    check("fill1_in_ready", 32'(bus.in_ready), 32'd1);
    push_one(32'h104, 32'hFE01_0113);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_head_pc", bus.out_pc, 32'h100);
    check("full_iimm", 32'(bus.iimm), 32'h005);
    check("full_i_smm", 32'(bus.i_smm), 32'd5);
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h108;
    bus.in_instr = 32'h0000_0033;
    tick();
    check("held_in_ready", 32'(bus.in_ready), 32'd0);
    check("held_head_pc", bus.out_pc, 32'h100);
    bus.out_ready = 1'b1;
    tick();
    check("drain_head1", bus.out_pc, 32'h104);
    tick();
    check("drain_head2", bus.out_pc, 32'h108);
    check("drain_instr2", bus.out_instr, 32'h0000_0033);
    bus.in_valid = 1'b0;
    tick();
    check("drain_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Streaming: one entry per cycle, count stays at 1.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_pc    = 32'h200 + 32'(4 * i);
      bus.in_instr = 32'(i);
      tick();
      check("stream_valid", 32'(bus.out_valid), 32'd1);
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      check("stream_pc", bus.out_pc, 32'h200 + 32'(4 * i));
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Immediate slices.
    push_one(32'h300, 32'hFE00_0EE3);
    check("bimm", 32'(bus.bimm), 32'h0FFE);
    pop_one();
    push_one(32'h304, 32'h8000_006F);
    check("jimm", 32'(bus.jimm), 32'h8_0000);
    pop_one();
    push_one(32'h308, 32'h1234_50B7);
    check("uimm", 32'(bus.uimm), 32'h1_2345);
    pop_one();
    push_one(32'h30C, 32'hFE11_2E23);
    check("simm", 32'(bus.simm), 32'h0FFC);
    pop_one();
    check("slice_empty_instr", bus.out_instr, 32'h0000_0013);

    // Flush on a full buffer with push and pop presented together.
    push_one(32'h400, 32'h0000_0001);
    push_one(32'h404, 32'h0000_0002);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h408;
    bus.in_instr  = 32'h0000_0003;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_out_pc", bus.out_pc, 32'h0);
`ifdef IFID_PERF_CNT_EN
    check("flush_drop_cnt", flush_drop_cnt, 32'd2);
`endif
    // Flush with a push that in_ready would otherwise accept.
    push_one(32'h410, 32'h0000_0004);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h414;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush2_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("flush2_still_empty", 32'(bus.out_valid), 32'd0);
`ifdef IFID_PERF_CNT_EN
    check("flush_drop_cnt2", flush_drop_cnt, 32'd3);
`endif

    // Wrap-around from pointers at 0: push, push, pop, push, pop.
    push_one(32'h500, 32'h0000_0A00);
    push_one(32'h504, 32'h0000_0A04);
    check("wrap_head_a", bus.out_pc, 32'h500);
    pop_one();
    check("wrap_head_b", bus.out_pc, 32'h504);
    push_one(32'h508, 32'h0000_0A08);
    check("wrap_full", 32'(bus.in_ready), 32'd0);
    check("wrap_head_b2", bus.out_pc, 32'h504);
    pop_one();
    check("wrap_head_c", bus.out_pc, 32'h508);
    check("wrap_instr_c", bus.out_instr, 32'h0000_0A08);
    pop_one();
    check("wrap_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset between clock edges.
    push_one(32'h600, 32'h0000_0B00);
    push_one(32'h604, 32'h0000_0B04);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_instr", bus.out_instr, 32'h0000_0013);
    check("arst_out_pc", bus.out_pc, 32'h0);
`ifdef IFID_PERF_CNT_EN
    check("arst_flush_drop", flush_drop_cnt, 32'd0);
    check("arst_stall", stall_cnt, 32'd0);
`endif
    tick();
    rst = 1'b0;
    push_one(32'h700, 32'h0000_0C00);
    check("post_rst_pc", bus.out_pc, 32'h700);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
